alu_mul_sequencer: RTL
======================

// Module: alu_mul_sequencer
// PURPOSE
//   Multi-cycle unsigned multiplier (low DATA_WIDTH bits of product) that sequences the
//   shared 32-bit ALU as its adder. Runs shift-and-add, one ALU ADD per cycle.
//   Sits beside the execute stage; the core hands it operands via valid/ready and
//   muxes the ALU inputs to this block while busy=1.
// PARAMETERS
//   DATA_WIDTH     32       operand/result width; also the number of RUN iterations
//   OPCODE_LENGTH  4        width of ALU Operation code
//   ALU_ADD_OP     4'b0010  ALU code driven during RUN (ADD)
// PORTS
//   clk         in   1              rising-edge clock
//   reset       in   1              synchronous, active-high
//   in_valid    in   1              operands presented
//   in_ready    out  1              block can accept operands (state IDLE)
//   op_a        in   DATA_WIDTH     multiplicand
//   op_b        in   DATA_WIDTH     multiplier
//   out_valid   out  1              product valid (state DONE)
//   out_ready   in   1              consumer takes product
//   product     out  DATA_WIDTH     low DATA_WIDTH bits of op_a*op_b, unsigned
//   busy        out  1              1 in RUN; core routes ALU to this block
//   alu_srca    out  DATA_WIDTH     to ALU SrcA
//   alu_srcb    out  DATA_WIDTH     to ALU SrcB
//   alu_op      out  OPCODE_LENGTH  to ALU Operation
//   alu_result  in   DATA_WIDTH     from ALU ALUResult (combinational, same cycle)
// BEHAVIOUR
//   One clock; reset synchronous, active-high. All state updates on rising clk.
//   Regs: state{IDLE,RUN,DONE}, acc, mcand, mplier (DATA_WIDTH), cnt ($clog2(DATA_WIDTH)+1).
//   Reset (any state, incl. mid-RUN): state=IDLE, acc/mcand/mplier/cnt=0; aborts op.
//     Outputs after reset: in_ready=1, out_valid=0, busy=0, product=0, alu_* =0.
//   IDLE: in_ready=1. in_valid=1 at edge -> mcand=op_a, mplier=op_b, acc=0, cnt=0, ->RUN.
//   RUN: busy=1; alu_op=ALU_ADD_OP, alu_srca=acc, alu_srcb=mplier[0]?mcand:0.
//     Each edge: acc<=alu_result; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
//     Edge with cnt==DATA_WIDTH-1 -> DONE. No early exit: fixed DATA_WIDTH RUN cycles.
//     Overflow past DATA_WIDTH bits discarded (wraps, via ALU ADD truncation).
//   DONE: out_valid=1, product=acc, held stable until out_ready=1 at an edge -> IDLE.
//   Outside RUN: alu_srca=alu_srcb=0, alu_op=0 (drive ALU idle-safe).
//   product = acc in DONE, 0 otherwise. in_ready, out_valid, busy decoded from state only.
//   Latency: accept edge E0; out_valid high from the cycle after edge E(DATA_WIDTH)
//     -> DATA_WIDTH+1 cycles from accept to valid. Throughput: 1 op per DATA_WIDTH+2 cycles
//     minimum (DONE->IDLE needs an edge; no accept in same cycle as out_ready).
//   in_valid during RUN/DONE ignored (in_ready=0); operands not latched.
//   out_ready outside DONE ignored. in_valid and out_ready both 1 in DONE: only handoff,
//     new op accepted no earlier than the following IDLE cycle.
//   Operands may change after accept without effect.
// TESTING
//   T1 reset, in_valid op_a=3 op_b=5 -> out_valid exactly 33 cycles after accept, product=15
//   T2 op_a=0xFFFFFFFF op_b=0xFFFFFFFF -> product=0x00000001; 0x00010000*0x00010000 -> 0
//   T3 during RUN check alu_op=4'b0010, alu_srcb=0 when mplier bit clear; in_valid pulses
//      with other operands mid-RUN -> ignored, result unchanged
//   T4 hold out_ready=0 for 10 cycles in DONE -> out_valid/product stable; out_ready=1 ->
//      IDLE next cycle, in_ready=1
//   T5 reset asserted at RUN cycle 12 -> next cycle IDLE, busy=0, out_valid=0; new op
//      7*6 then completes with product=42
//   T6 back-to-back: 1000 random operand pairs vs reference a*b mod 2^32, random out_ready

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned multiplier that borrows the shared ALU as its adder.
// Shift-and-add: one ALU ADD per RUN cycle, fixed DATA_WIDTH iterations,
// low DATA_WIDTH bits of the product returned through a valid/ready handshake.
module alu_mul_sequencer #(
  parameter int unsigned                DATA_WIDTH    = 32,
  parameter int unsigned                OPCODE_LENGTH = 4,
  parameter logic [OPCODE_LENGTH-1:0]   ALU_ADD_OP    = 4'b0010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    op_a,
  input  logic [DATA_WIDTH-1:0]    op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    product,
  output logic                     busy,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_op,
  input  logic [DATA_WIDTH-1:0]    alu_result
);

  localparam int unsigned         CntW    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0]     CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0]   mplier_q, mplier_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state: latch operands on accept, one shift-and-add step per RUN cycle.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // ALU sum wraps at DATA_WIDTH bits, which gives the low half of the product.
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; ALU inputs held at zero whenever not running.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    product   = '0;
    alu_srca  = '0;
    alu_srcb  = '0;
    alu_op    = '0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StRun: begin
        busy     = 1'b1;
        alu_op   = ALU_ADD_OP;
        alu_srca = acc_q;
        alu_srcb = mplier_q[0] ? mcand_q : '0;
      end
      StDone: begin
        out_valid = 1'b1;
        product   = acc_q;
      end
      default: ;
    endcase
  end

endmodule
